// File: rtl/sme_param.sv
// sme_param: string-matching engine. Holds one string, then searches it for
// each pattern that follows, reporting first-hit index and hit count.
// Supports '.' wildcard and '^' / '$' word anchors (space-delimited words).
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting; results of the last search held on the outputs
// LOAD_STR | appending string characters
// LOAD_PAT | appending pattern characters and anchors
// SEARCH   | evaluating one candidate start position per cycle
module sme_param #(
  parameter int CHAR_W  = 8,
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int IDX_W   = $clog2(STR_MAX)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  output logic              valid,
  output logic              match,
  output logic [IDX_W-1:0]  match_index,
  output logic [IDX_W:0]    match_count,
  output logic              overflow,
  output logic              busy
);

  localparam int LEN_W  = IDX_W + 1;
  localparam int PLEN_W = $clog2(PAT_MAX + 1);
  localparam int PIW    = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
  // common width wide enough for any sum of a string and a pattern length
  localparam int CW     = ((LEN_W > PLEN_W) ? LEN_W : PLEN_W) + 1;

  localparam logic [LEN_W-1:0]  STR_MAX_L = LEN_W'(STR_MAX);
  localparam logic [PLEN_W-1:0] PAT_MAX_L = PLEN_W'(PAT_MAX);
  localparam logic [CW-1:0]     STR_MAX_C = CW'(STR_MAX);
  localparam logic [CW-1:0]     ONE_C     = CW'(1);
  localparam logic [IDX_W-1:0]  ONE_I     = IDX_W'(1);

  localparam logic [CHAR_W-1:0] CH_CARET  = CHAR_W'(8'h5E);
  localparam logic [CHAR_W-1:0] CH_DOLLAR = CHAR_W'(8'h24);
  localparam logic [CHAR_W-1:0] CH_DOT    = CHAR_W'(8'h2E);
  localparam logic [CHAR_W-1:0] CH_SPACE  = CHAR_W'(8'h20);

  typedef enum logic [1:0] {IDLE, LOAD_STR, LOAD_PAT, SEARCH} state_t;

  state_t             state, state_nx;
  logic [CHAR_W-1:0]  str_mem [STR_MAX];
  logic [CHAR_W-1:0]  pat_mem [PAT_MAX];
  logic [LEN_W-1:0]   str_len;
  logic [PLEN_W-1:0]  pat_len;
  logic               str_ovf, pat_ovf, caret, dollar;
  logic [IDX_W-1:0]   s_cnt;

  logic               load_ok, str_first, pat_first, pat_take;
  logic               is_caret, is_dollar, str_we, pat_we;
  logic [IDX_W-1:0]   str_waddr;
  logic [PIW-1:0]     pat_waddr;

  logic [CW-1:0]      str_len_c, pat_len_c, s_c, n_cand, end_c;
  logic [IDX_W-1:0]   prev_idx;
  logic [PAT_MAX-1:0] pos_ok;
  logic               anchor_ok, hit, s_last;

  assign str_len_c = CW'(str_len);
  assign pat_len_c = CW'(pat_len);
  assign s_c       = CW'(s_cnt);
  assign busy      = (state == SEARCH);

  // load-side decode: which buffer is written this cycle and where
  always_comb begin
    load_ok   = (state != SEARCH);
    str_first = (state != LOAD_STR);
    pat_first = (state != LOAD_PAT);
    pat_take  = load_ok && !isstring && ispattern;
    is_caret  = (chardata == CH_CARET) && pat_first;
    is_dollar = (chardata == CH_DOLLAR);
    str_we    = load_ok && isstring && (str_first || (str_len < STR_MAX_L));
    str_waddr = str_first ? '0 : str_len[IDX_W-1:0];
    pat_we    = pat_take && !is_caret && !is_dollar
                && (pat_first || (pat_len < PAT_MAX_L));
    pat_waddr = pat_first ? '0 : pat_len[PIW-1:0];
  end

  // per-position character compare for the current candidate, all in parallel
  for (genvar gi = 0; gi < PAT_MAX; gi++) begin : g_pos
    logic [CW-1:0] idx;
    logic          ok;
    always_comb begin
      idx = s_c + CW'(gi);
      ok  = 1'b1;
      if ((CW'(gi) < pat_len_c) && (idx < STR_MAX_C)) begin
        if ((pat_mem[gi] != CH_DOT) && (pat_mem[gi] != str_mem[idx[IDX_W-1:0]]))
          ok = 1'b0;
      end
    end
    assign pos_ok[gi] = ok;
  end

  // candidate count, anchor checks and the hit decision
  always_comb begin
    n_cand = '0;
    if ((pat_len_c != '0) && (pat_len_c <= str_len_c))
      n_cand = str_len_c - pat_len_c + ONE_C;
    anchor_ok = 1'b1;
    prev_idx  = s_cnt - ONE_I;
    if (caret && (s_cnt != '0) && (str_mem[prev_idx] != CH_SPACE))
      anchor_ok = 1'b0;
    end_c = s_c + pat_len_c;
    if (dollar && (end_c < str_len_c) && (str_mem[end_c[IDX_W-1:0]] != CH_SPACE))
      anchor_ok = 1'b0;
    hit    = (n_cand != '0) && (&pos_ok) && anchor_ok;
    s_last = (n_cand == '0) || (s_c == n_cand - ONE_C);
  end

  // next-state logic; isstring wins over ispattern
  always_comb begin
    state_nx = state;
    case (state)
      SEARCH: if (s_last) state_nx = IDLE;
      default: begin
        if (isstring)               state_nx = LOAD_STR;
        else if (ispattern)         state_nx = LOAD_PAT;
        else if (state == LOAD_PAT) state_nx = SEARCH;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // character buffers; contents beyond the current lengths are never read
  always_ff @(posedge clk) begin
    if (str_we) str_mem[str_waddr] <= chardata;
    if (pat_we) pat_mem[pat_waddr] <= chardata;
  end

  // lengths, anchor flags, candidate counter and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      str_len     <= '0;
      pat_len     <= '0;
      str_ovf     <= 1'b0;
      pat_ovf     <= 1'b0;
      caret       <= 1'b0;
      dollar      <= 1'b0;
      s_cnt       <= '0;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (load_ok && isstring) begin
        if (str_first) begin
          str_len <= LEN_W'(1);
          str_ovf <= 1'b0;
        end else if (str_len < STR_MAX_L) begin
          str_len <= str_len + LEN_W'(1);
        end else begin
          str_ovf <= 1'b1;
        end
      end else if (pat_take) begin
        if (pat_first) begin
          pat_len     <= '0;
          pat_ovf     <= 1'b0;
          caret       <= 1'b0;
          dollar      <= 1'b0;
          match       <= 1'b0;
          match_index <= '0;
          match_count <= '0;
          overflow    <= 1'b0;
        end
        if (is_caret)                 caret   <= 1'b1;
        else if (is_dollar)           dollar  <= 1'b1;
        else if (pat_first)           pat_len <= PLEN_W'(1);
        else if (pat_len < PAT_MAX_L) pat_len <= pat_len + PLEN_W'(1);
        else                          pat_ovf <= 1'b1;
      end else if (state == LOAD_PAT) begin
        s_cnt <= '0;
      end
      if (state == SEARCH) begin
        s_cnt <= s_cnt + ONE_I;
        if (hit) begin
          if (!match) begin
            match       <= 1'b1;
            match_index <= s_cnt;
          end
          match_count <= match_count + LEN_W'(1);
        end
        if (s_last) begin
          valid    <= 1'b1;
          overflow <= str_ovf | pat_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_sme_param.sv
// tb_sme_param: directed vector table for sme_param plus hand-written
// sequences for reset state and reset abort during a search.
module tb_sme_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] chardata;
  logic       isstring, ispattern;
  logic       valid, match, overflow, busy;
  logic [4:0] match_index;
  logic [5:0] match_count;

  int n_tests = 0;
  int n_fail  = 0;

  sme_param dut (
    .clk         (clk),
    .reset       (reset),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .valid       (valid),
    .match       (match),
    .match_index (match_index),
    .match_count (match_count),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string str;    // empty: keep the previous string
    string pat;
    bit    both;   // drive string chars with ispattern also high
    int    pulse;  // search cycle at which to pulse ispattern (0 = none)
    int    em, ei, ec, eo, el;  // match, index, count, overflow, latency
  } vec_t;

  vec_t vec [17];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input string t, input bit s, input bit p);
    for (int i = 0; i < t.len(); i++) begin
      @(negedge clk);
      chardata  = t[i];
      isstring  = s;
      ispattern = p;
    end
  endtask

  task automatic run_case(input int k, input vec_t v);
    int lat;
    bit got;
    string tag;
    tag = $sformatf("v%0d", k);
    if (v.str.len() > 0) send(v.str, 1'b1, v.both);
    send(v.pat, 1'b0, 1'b1);
    @(negedge clk);
    isstring  = 1'b0;
    ispattern = 1'b0;
    chardata  = 8'h00;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      ispattern = 1'b0;
      if (valid) got = 1'b1;
      else begin
        if (lat == 1) check({tag, " busy_in_search"}, int'(busy), 1);
        if (v.pulse != 0 && lat == v.pulse) begin
          ispattern = 1'b1;
          chardata  = 8'h68;
        end
      end
    end
    check({tag, " valid_seen"}, int'(got), 1);
    check({tag, " latency"}, lat, v.el);
    check({tag, " match"}, int'(match), v.em);
    check({tag, " index"}, int'(match_index), v.ei);
    check({tag, " count"}, int'(match_count), v.ec);
    check({tag, " overflow"}, int'(overflow), v.eo);
    check({tag, " busy_done"}, int'(busy), 0);
    @(negedge clk);
    check({tag, " valid_one_cycle"}, int'(valid), 0);
  endtask

  initial begin
    vec_t v;
    int seen;
    vec[0]  = '{"", "a", 0, 0, 0, 0, 0, 0, 2};
    vec[1]  = '{"hello world", "o", 0, 0, 1, 4, 2, 0, 12};
    vec[2]  = '{"", "^wor", 0, 0, 1, 6, 1, 0, 10};
    vec[3]  = '{"", "lo$", 0, 0, 1, 3, 1, 0, 11};
    vec[4]  = '{"", "^h.llo$", 0, 0, 1, 0, 1, 0, 8};
    vec[5]  = '{"", "^orld", 0, 0, 0, 0, 0, 0, 9};
    vec[6]  = '{"", "o", 0, 3, 1, 4, 2, 0, 12};
    vec[7]  = '{"aaaa", "aa", 0, 0, 1, 0, 3, 0, 4};
    vec[8]  = '{"", "aaaaa", 0, 0, 0, 0, 0, 0, 2};
    vec[9]  = '{"abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMN", "F", 0, 0, 1, 31, 1, 1, 33};
    vec[10] = '{"", "G", 0, 0, 0, 0, 0, 1, 33};
    vec[11] = '{"hello world", "hello woX", 0, 0, 1, 0, 1, 1, 5};
    vec[12] = '{"hello world", "l", 0, 0, 1, 2, 3, 0, 12};
    vec[13] = '{"xy", "y", 1, 0, 1, 1, 1, 0, 3};
    vec[14] = '{"a b a", ".", 0, 0, 1, 0, 5, 0, 6};
    vec[15] = '{"", "a$", 0, 0, 1, 0, 2, 0, 6};
    vec[16] = '{"", "^b", 0, 0, 1, 2, 1, 0, 6};

    reset     = 1'b1;
    chardata  = 8'h00;
    isstring  = 1'b0;
    ispattern = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", int'({valid, match, match_index, match_count, overflow, busy}), 0);
    reset = 1'b0;

    for (int k = 0; k < 17; k++) run_case(k, vec[k]);

    // reset while candidate 3 of "hello world"/"d" is being evaluated
    send("hello world", 1'b1, 1'b0);
    send("d", 1'b0, 1'b1);
    @(negedge clk);
    isstring  = 1'b0;
    ispattern = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("abort_outputs", int'({valid, match, match_index, match_count, overflow, busy}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (valid || busy) seen++;
    end
    check("abort_no_valid", seen, 0);

    v = '{"hello world", "d", 0, 0, 1, 10, 1, 0, 12};
    run_case(17, v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
